// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next control-store address by branch type,
// with memory-wait stalls, debug halt/single-step and an advance counter.
module micro_sequencer #(
    parameter int unsigned MICRO_SEQUENCER_ADDR  = 11,
    parameter int unsigned MICRO_SEQUENCER_TIPO  = 2,
    parameter int unsigned MICRO_SEQUENCER_IR    = 32,
    parameter int unsigned MICRO_SEQUENCER_COUNT = 16
) (
    input  logic                             MICRO_SEQUENCER_CLOCK_50,
    input  logic                             MICRO_SEQUENCER_ResetInHigh_In,
    input  logic [MICRO_SEQUENCER_TIPO-1:0]  MICRO_SEQUENCER_Tipo_InBus,
    input  logic [MICRO_SEQUENCER_ADDR-1:0]  MICRO_SEQUENCER_JumpAddr_InBus,
    input  logic [MICRO_SEQUENCER_IR-1:0]    MICRO_SEQUENCER_IR_InBus,
    input  logic                             MICRO_SEQUENCER_MemReq_In,
    input  logic                             MICRO_SEQUENCER_MemReady_In,
    input  logic                             MICRO_SEQUENCER_Halt_In,
    input  logic                             MICRO_SEQUENCER_Step_In,
    output logic [MICRO_SEQUENCER_ADDR-1:0]  MICRO_SEQUENCER_CSAddr_OutBus,
    output logic                             MICRO_SEQUENCER_Stall_Out,
    output logic                             MICRO_SEQUENCER_IllegalTipo_Out,
    output logic [MICRO_SEQUENCER_COUNT-1:0] MICRO_SEQUENCER_MicroCount_OutBus
);

    localparam int unsigned AW = MICRO_SEQUENCER_ADDR;
    localparam int unsigned CW = MICRO_SEQUENCER_COUNT;

    typedef enum logic [1:0] {StRun, StWait, StHalt} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d, next_addr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            advance;
    logic            mem_blocked;
    logic [10:0]     decode_addr;

    assign mem_blocked = MICRO_SEQUENCER_MemReq_In & ~MICRO_SEQUENCER_MemReady_In;
    assign decode_addr = {1'b1, MICRO_SEQUENCER_IR_InBus[31:30],
                          MICRO_SEQUENCER_IR_InBus[24:19], 2'b00};

    always_comb begin
        next_addr = addr_q + AW'(1);
        unique case (MICRO_SEQUENCER_Tipo_InBus)
            2'b01:   next_addr = MICRO_SEQUENCER_JumpAddr_InBus;
            2'b10:   next_addr = AW'(decode_addr);
            default: next_addr = addr_q + AW'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_blocked) begin
                    state_d = StWait;
                end else if (MICRO_SEQUENCER_Halt_In) begin
                    state_d = StHalt;
                end else begin
                    advance = 1'b1;
                end
            end
            StWait: begin
                if (MICRO_SEQUENCER_MemReady_In) begin
                    advance = 1'b1;
                    state_d = MICRO_SEQUENCER_Halt_In ? StHalt : StRun;
                end
            end
            StHalt: begin
                // Releasing halt takes priority over a concurrent step.
                if (!MICRO_SEQUENCER_Halt_In) begin
                    state_d = StRun;
                end else if (MICRO_SEQUENCER_Step_In) begin
                    if (mem_blocked) begin
                        state_d = StWait;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        if (advance) begin
            addr_d = next_addr;
            cnt_d  = cnt_q + CW'(1);
            if (MICRO_SEQUENCER_Tipo_InBus == 2'b11) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
        if (MICRO_SEQUENCER_ResetInHigh_In) begin
            state_q   <= StRun;
            addr_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign MICRO_SEQUENCER_CSAddr_OutBus     = addr_q;
    assign MICRO_SEQUENCER_Stall_Out         = (state_q != StRun);
    assign MICRO_SEQUENCER_IllegalTipo_Out   = illegal_q;
    assign MICRO_SEQUENCER_MicroCount_OutBus = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios then randomized
// traffic, all checked against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tipo;
    logic [10:0] jaddr;
    logic [31:0] ir;
    logic        mreq, mrdy, halt, step;
    logic [10:0] cs_addr;
    logic        stall, illegal;
    logic [15:0] mcount;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .MICRO_SEQUENCER_CLOCK_50          (clk),
        .MICRO_SEQUENCER_ResetInHigh_In    (rst),
        .MICRO_SEQUENCER_Tipo_InBus        (tipo),
        .MICRO_SEQUENCER_JumpAddr_InBus    (jaddr),
        .MICRO_SEQUENCER_IR_InBus          (ir),
        .MICRO_SEQUENCER_MemReq_In         (mreq),
        .MICRO_SEQUENCER_MemReady_In       (mrdy),
        .MICRO_SEQUENCER_Halt_In           (halt),
        .MICRO_SEQUENCER_Step_In           (step),
        .MICRO_SEQUENCER_CSAddr_OutBus     (cs_addr),
        .MICRO_SEQUENCER_Stall_Out         (stall),
        .MICRO_SEQUENCER_IllegalTipo_Out   (illegal),
        .MICRO_SEQUENCER_MicroCount_OutBus (mcount)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = halted.
    int m_addr = 0;
    int m_cnt  = 0;
    int m_mode = 0;
    bit m_ill  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit adv;
        bit blocked;
        adv     = 0;
        blocked = mreq && !mrdy;
        if (rst) begin
            m_addr = 0; m_cnt = 0; m_mode = 0; m_ill = 0;
        end else begin
            if (m_mode == 0) begin
                if (blocked) m_mode = 1;
                else if (halt) m_mode = 2;
                else adv = 1;
            end else if (m_mode == 1) begin
                if (mrdy) begin
                    adv = 1;
                    m_mode = halt ? 2 : 0;
                end
            end else begin
                if (!halt) m_mode = 0;
                else if (step) begin
                    if (blocked) m_mode = 1;
                    else adv = 1;
                end
            end
            if (adv) begin
                case (tipo)
                    2'd1:    m_addr = int'(jaddr);
                    2'd2:    m_addr = 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
                    default: m_addr = (m_addr + 1) % 2048;
                endcase
                if (tipo == 2'd3) m_ill = 1;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("addr",    32'(cs_addr), 32'(m_addr));
        check("count",   32'(mcount),  32'(m_cnt));
        check("stall",   32'(stall),   32'(m_mode != 0));
        check("illegal", 32'(illegal), 32'(m_ill));
    endtask

    task automatic idle_inputs();
        tipo = 2'd0; jaddr = '0; ir = '0;
        mreq = 0; mrdy = 0; halt = 0; step = 0;
    endtask

    int cnt_before;

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        tick();
        check("rst_addr", 32'(cs_addr), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_count", 32'(mcount), 32'd0);

        // Sequential advance right after reset release.
        rst = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_addr", 32'(cs_addr), 32'(i));
        end
        check("seq_count", 32'(mcount), 32'd3);
        check("seq_stall", 32'(stall), 32'd0);

        tipo = 2'd1; jaddr = 11'd5;    tick();
        jaddr = 11'h400;               tick();
        check("jump", 32'(cs_addr), 32'h400);

        tipo = 2'd2; ir = 32'h8200_0000; tick();
        check("decode0", 32'(cs_addr), 32'h600);
        ir = 32'h8280_0000;              tick();
        check("decode1", 32'(cs_addr), 32'h640);

        // Memory wait at address 7.
        tipo = 2'd1; jaddr = 11'd7; tick();
        tipo = 2'd0; mreq = 1; mrdy = 0;
        cnt_before = m_cnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_addr", 32'(cs_addr), 32'd7);
        end
        mrdy = 1; tick();
        check("wait_done", 32'(cs_addr), 32'd8);
        check("wait_cnt", 32'(mcount), 32'(cnt_before + 1));
        mreq = 0; mrdy = 0;

        // Halt with two single steps.
        tipo = 2'd1; jaddr = 11'd10; tick();
        tipo = 2'd0; halt = 1; tick();
        check("halt_addr", 32'(cs_addr), 32'd10);
        check("halt_stall", 32'(stall), 32'd1);
        step = 1; tick(); check("step1", 32'(cs_addr), 32'd11);
        step = 0; tick(); check("step_hold", 32'(cs_addr), 32'd11);
        step = 1; tick(); check("step2", 32'(cs_addr), 32'd12);
        step = 0; halt = 0; tick();
        check("resume", 32'(cs_addr), 32'd12);
        check("resume_stall", 32'(stall), 32'd0);
        tick(); check("resume_adv", 32'(cs_addr), 32'd13);

        // Illegal branch type at the top of the address space.
        tipo = 2'd1; jaddr = 11'd2047; tick();
        tipo = 2'd3; tick();
        check("illegal_wrap", 32'(cs_addr), 32'd0);
        check("illegal_set", 32'(illegal), 32'd1);
        tipo = 2'd0; repeat (3) tick();
        check("illegal_sticky", 32'(illegal), 32'd1);

        // Reset while waiting on memory.
        mreq = 1; mrdy = 0; tick();
        check("prewait_stall", 32'(stall), 32'd1);
        rst = 1; tick();
        check("rstw_addr", 32'(cs_addr), 32'd0);
        check("rstw_count", 32'(mcount), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        check("rstw_illegal", 32'(illegal), 32'd0);
        rst = 0; mreq = 0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            tipo  = 2'($urandom_range(0, 3));
            jaddr = 11'($urandom);
            ir    = $urandom;
            mreq  = ($urandom_range(0, 2) == 0);
            mrdy  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            step  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
